// File: rtl/arbiter_pipein2fifo_pkg.sv
// rtl/arbiter_pipein2fifo_pkg.sv - shared constants and state encodings for the pipe arbiters
//
// Purpose: lane geometry and the FSM state encodings. The pipe-out arbiter
// uses the same encodings, so keep the values stable.
package arbiter_pipein2fifo_pkg;

  localparam int NUM_CORES = 8;
  localparam int WORD_W    = 32;

  // 2'd0 is never entered on purpose; the FSM treats it as illegal and
  // recovers to IDLE.
  typedef enum logic [1:0] {
    STATE_ILLEGAL    = 2'd0,
    STATE_IDLE       = 2'd1,
    STATE_CHECK_ADDR = 2'd2,
    STATE_TRANSFER   = 2'd3
  } state_t;

endpackage

// File: rtl/arbiter_pipein2fifo_fifo_cdc.sv
// rtl/arbiter_pipein2fifo_fifo_cdc.sv - dual-clock FWFT word FIFO between host and core clocks
//
// Purpose: buffers 32-bit host words written on ok_clk and presents them
// first-word-fall-through on clk. FIFO_SIZE=4096 selects the 4096-deep
// variant, any other value the 256-deep one.
// Ports:
//   rst            async active-high reset, clears both sides
//   ok_clk         write clock
//   din/wr_en      write word and strobe (dropped while full)
//   full           registered full flag, ok_clk domain
//   clk            read clock
//   rd_en          pop the word currently on dout (ignored while empty)
//   dout/empty     head word and registered empty flag, clk domain
module pipein_fifo_cdc
  import arbiter_pipein2fifo_pkg::*;
#(
  parameter int FIFO_SIZE = 256
) (
  input  logic              rst,
  input  logic              ok_clk,
  input  logic [WORD_W-1:0] din,
  input  logic              wr_en,
  output logic              full,
  input  logic              clk,
  input  logic              rd_en,
  output logic [WORD_W-1:0] dout,
  output logic              empty
);

  localparam int ADDR_W = (FIFO_SIZE == 4096) ? 12 : 8;
  localparam int PTR_W  = ADDR_W + 1;
  localparam int DEPTH  = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wbin, wgray, wbin_next, wgray_next;
  logic [PTR_W-1:0] rbin, rgray, rbin_next, rgray_next;
  logic [PTR_W-1:0] rgray_s1, rgray_s2;  // read pointer seen in ok_clk
  logic [PTR_W-1:0] wgray_s1, wgray_s2;  // write pointer seen in clk

  // Pointers carry one extra wrap bit; Gray coding makes the two-flop
  // synchronisers safe because only one bit changes per increment.
  assign wbin_next  = wbin + PTR_W'(wr_en && !full);
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  assign rbin_next  = rbin + PTR_W'(rd_en && !empty);
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;

  always_ff @(posedge ok_clk or posedge rst) begin
    if (rst) begin
      wbin     <= '0;
      wgray    <= '0;
      rgray_s1 <= '0;
      rgray_s2 <= '0;
      full     <= 1'b0;
    end else begin
      wbin     <= wbin_next;
      wgray    <= wgray_next;
      rgray_s1 <= rgray;
      rgray_s2 <= rgray_s1;
      // Full in Gray space: top two bits inverted, the rest equal.
      full     <= (wgray_next == {~rgray_s2[PTR_W-1 -: 2], rgray_s2[PTR_W-3:0]});
    end
  end

  always_ff @(posedge ok_clk) begin
    if (wr_en && !full) begin
      mem[wbin[ADDR_W-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbin     <= '0;
      rgray    <= '0;
      wgray_s1 <= '0;
      wgray_s2 <= '0;
      empty    <= 1'b1;
    end else begin
      rbin     <= rbin_next;
      rgray    <= rgray_next;
      wgray_s1 <= wgray;
      wgray_s2 <= wgray_s1;
      empty    <= (rgray_next == wgray_s2);
    end
  end

  // Fall-through: the head word is always on dout while not empty.
  assign dout = mem[rbin[ADDR_W-1:0]];

endmodule

// File: rtl/arbiter_pipein2fifo.sv
// rtl/arbiter_pipein2fifo.sv - host pipe-in to per-core input FIFO distributor
//
// Purpose: host words arrive on ok_clk into a CDC FIFO; in clk a state
// machine walks the selected cores in ascending order and pushes exactly
// num_words words into each selected core's input FIFO.
// Ports:
//   clk, rst         core clock, async active-high reset (also clears the FIFO)
//   ok_clk           host clock
//   pipe_in          host word, written when pipe_in_write is high
//   pipe_in_full     internal FIFO full (ok_clk); writes while full are lost
//   core_select      bit i set = core i receives a block (sampled live)
//   num_words        words per selected core, 0 = no writes (sampled live)
//   idle             high only while the FSM sits in IDLE
//   data_to_fifo     lane i on bits [32i+31:32i]; only the active lane is non-zero
//   wr_en_to_fifo    one-hot write strobe to the core FIFOs
//   full_from_fifo   per-core FIFO full; stalls the active lane
module arbiter_pipein2fifo #(
  parameter int FIFO_SIZE = 256,
  parameter int NUM_CORES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ok_clk,
  input  logic [31:0]             pipe_in,
  input  logic                    pipe_in_write,
  output logic                    pipe_in_full,
  input  logic [NUM_CORES-1:0]    core_select,
  input  logic [7:0]              num_words,
  output logic                    idle,
  output logic [NUM_CORES*32-1:0] data_to_fifo,
  output logic [NUM_CORES-1:0]    wr_en_to_fifo,
  input  logic [NUM_CORES-1:0]    full_from_fifo
);

  import arbiter_pipein2fifo_pkg::*;

  state_t      state;
  logic [3:0]  addr_counter;
  logic [7:0]  write_counter;

  logic [WORD_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              push;
  logic              block_done;
  logic [2:0]        lane;

  pipein_fifo_cdc #(.FIFO_SIZE(FIFO_SIZE)) u_fifo (
    .rst   (rst),
    .ok_clk(ok_clk),
    .din   (pipe_in),
    .wr_en (pipe_in_write),
    .full  (pipe_in_full),
    .clk   (clk),
    .rd_en (push),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  // TRANSFER is only entered with addr_counter < 8, so the low bits index the lane.
  assign lane       = addr_counter[2:0];
  assign block_done = (write_counter == num_words);

  // Pop and core write happen in the same cycle: the FWFT head word is
  // already on dout, so no extra latency between FIFO and core.
  assign push = (state == STATE_TRANSFER) && !block_done &&
                !fifo_empty && !full_from_fifo[lane];

  always_comb begin
    idle          = (state == STATE_IDLE);
    data_to_fifo  = '0;
    wr_en_to_fifo = '0;
    if (state == STATE_TRANSFER && !block_done) begin
      data_to_fifo[lane*32 +: 32] = fifo_dout;
    end
    if (push) begin
      wr_en_to_fifo[lane] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= STATE_IDLE;
      addr_counter  <= '0;
      write_counter <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          addr_counter  <= '0;
          write_counter <= '0;
          if (!fifo_empty && core_select != '0) begin
            state <= STATE_CHECK_ADDR;
          end
        end
        STATE_CHECK_ADDR: begin
          if (addr_counter[3]) begin
            state <= STATE_IDLE;
          end else if (core_select[lane]) begin
            write_counter <= '0;
            state         <= STATE_TRANSFER;
          end else begin
            addr_counter <= addr_counter + 4'd1;
          end
        end
        STATE_TRANSFER: begin
          if (block_done) begin
            addr_counter <= addr_counter + 4'd1;
            state        <= STATE_CHECK_ADDR;
          end else if (push) begin
            write_counter <= write_counter + 8'd1;
          end
        end
        default: begin
          addr_counter  <= '0;
          write_counter <= '0;
          state         <= STATE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_pipein2fifo.sv
// tb/tb_arbiter_pipein2fifo.sv - self-checking bench for arbiter_pipein2fifo
module tb_arbiter_pipein2fifo;

  logic         clk = 1'b0;
  logic         ok_clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  pipe_in = '0;
  logic         pipe_in_write = 1'b0;
  logic         pipe_in_full;
  logic [7:0]   core_select = '0;
  logic [7:0]   num_words = '0;
  logic         idle;
  logic [255:0] data_to_fifo;
  logic [7:0]   wr_en_to_fifo;
  logic [7:0]   full_from_fifo = '0;

  always #5 clk = ~clk;
  always #7 ok_clk = ~ok_clk;

  arbiter_pipein2fifo #(.FIFO_SIZE(256), .NUM_CORES(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .ok_clk        (ok_clk),
    .pipe_in       (pipe_in),
    .pipe_in_write (pipe_in_write),
    .pipe_in_full  (pipe_in_full),
    .core_select   (core_select),
    .num_words     (num_words),
    .idle          (idle),
    .data_to_fifo  (data_to_fifo),
    .wr_en_to_fifo (wr_en_to_fifo),
    .full_from_fifo(full_from_fifo)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the host word stream and, in delivery order, which
  // core each word must land in.
  typedef struct packed {
    logic [2:0]  core;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] host_q[$];
  int          wr_cnt[8];

  logic [7:0]  forced_full = '0;
  logic [7:0]  rand_mask = '0;
  bit          rand_en = 1'b0;

  // Sole driver of full_from_fifo: forced bits plus optional random stalls.
  always @(posedge clk) begin
    #1;
    full_from_fifo = forced_full |
                     ((rand_en && $urandom_range(0, 3) == 0) ? rand_mask : 8'h00);
  end

  int          mon_idx;
  exp_t        mon_e;
  logic [255:0] mon_vec;

  always @(negedge clk) begin
    if (!rst && wr_en_to_fifo != 8'h00) begin
      mon_idx = 0;
      for (int i = 7; i >= 0; i--) if (wr_en_to_fifo[i]) mon_idx = i;
      check("wr_onehot", $countones(wr_en_to_fifo), 1);
      check("wr_while_full", wr_en_to_fifo & full_from_fifo, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_wr", wr_en_to_fifo, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_core", mon_idx, mon_e.core);
        check("wr_data", data_to_fifo[mon_idx*32 +: 32], mon_e.word);
        mon_vec = '0;
        mon_vec[mon_e.core*32 +: 32] = mon_e.word;
        check("other_lanes_zero", data_to_fifo == mon_vec, 1);
      end
      wr_cnt[mon_idx]++;
    end
  end

  task automatic clear_counts();
    for (int i = 0; i < 8; i++) wr_cnt[i] = 0;
  endtask

  // Builds the host stream and the expected delivery order from the rules:
  // ascending selected cores, nw words each.
  task automatic plan(input logic [7:0] sel, input int nw, input logic [31:0] base);
    int k;
    k = 0;
    core_select = sel;
    num_words = 8'(nw);
    for (int c = 0; c < 8; c++) begin
      if (sel[c]) begin
        for (int j = 0; j < nw; j++) begin
          exp_q.push_back('{core: 3'(c), word: base + 32'(k)});
          host_q.push_back(base + 32'(k));
          k++;
        end
      end
    end
  endtask

  task automatic host_send(input int gap);
    int guard;
    for (int i = 0; i < host_q.size(); i++) begin
      @(negedge ok_clk);
      guard = 0;
      while (pipe_in_full && guard < 5000) begin
        pipe_in_write = 1'b0;
        @(negedge ok_clk);
        guard++;
      end
      if (guard >= 5000) check("host_full_timeout", guard, 0);
      pipe_in = host_q[i];
      pipe_in_write = 1'b1;
      if (gap > 0) begin
        @(negedge ok_clk);
        pipe_in_write = 1'b0;
        repeat (gap - 1) @(negedge ok_clk);
      end
    end
    @(negedge ok_clk);
    pipe_in_write = 1'b0;
    host_q.delete();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    n = 0;
    while (!idle && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_end"}, idle, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  n;
  int  held_before;
  bit  saw_busy;
  int  total;

  initial begin
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check("reset_idle", idle, 1);
    check("reset_wr_en", wr_en_to_fifo, 0);
    check("reset_data", data_to_fifo == '0, 1);
    check("reset_pipe_in_full", pipe_in_full, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Two cores, 4 words each.
    plan(8'h05, 4, 32'h100);
    host_send(0);
    wait_drain("t1", 500);
    check("t1_core0_cnt", wr_cnt[0], 4);
    check("t1_core2_cnt", wr_cnt[2], 4);
    clear_counts();

    // Core 7 stalled by its full flag after the first write.
    plan(8'h80, 3, $urandom);
    fork
      host_send(0);
    join_none
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (wr_cnt[7] < 1 && n < 500);
    check("t2_first_write_seen", wr_cnt[7] >= 1, 1);
    forced_full = 8'h80;
    @(posedge clk); #2;
    held_before = wr_cnt[7];
    repeat (5) @(posedge clk);
    #2;
    check("t2_held_while_full", wr_cnt[7], held_before);
    forced_full = 8'h00;
    wait fork;
    wait_drain("t2", 500);
    check("t2_core7_cnt", wr_cnt[7], 3);
    clear_counts();

    // num_words=0 with every core selected: walks all lanes, no writes.
    core_select = 8'hFF;
    num_words = 8'd0;
    host_q.push_back(32'hABC0_0001);
    host_send(0);
    saw_busy = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (!idle) saw_busy = 1'b1;
    end
    check("t3_fsm_walked", saw_busy, 1);
    total = 0;
    for (int i = 0; i < 8; i++) total += wr_cnt[i];
    check("t3_no_writes", total, 0);
    n = 0;
    while (!idle && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t3_idle_seen", idle, 1);
    core_select = 8'h01;
    num_words = 8'd1;
    exp_q.push_back('{core: 3'd0, word: 32'hABC0_0001});
    wait_drain("t3", 200);
    check("t3_word_retained", wr_cnt[0], 1);
    clear_counts();

    // 255 words to core 1 with random core-full stalls.
    rand_mask = 8'h02;
    rand_en = 1'b1;
    plan(8'h02, 255, $urandom);
    host_send(0);
    wait_drain("t4", 20000);
    rand_en = 1'b0;
    check("t4_core1_cnt", wr_cnt[1], 255);
    clear_counts();

    // Trickled host words: FSM stalls on empty.
    plan(8'h10, 6, $urandom);
    host_send(6);
    wait_drain("t5", 2000);
    check("t5_core4_cnt", wr_cnt[4], 6);
    clear_counts();

    // Reset after 2 of 4 words to core 3, then a clean block.
    forced_full = 8'h08;
    plan(8'h08, 4, 32'h300);
    host_send(0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    forced_full = 8'h00;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (wr_cnt[3] < 2 && n < 200);
    check("t6_two_before_rst", wr_cnt[3], 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_idle", idle, 1);
    check("t6_rst_wr_en", wr_en_to_fifo, 0);
    check("t6_rst_data", data_to_fifo == '0, 1);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_fifo_flushed", idle, 1);
    check("t6_cnt_after_rst", wr_cnt[3], 2);
    clear_counts();
    plan(8'h08, 4, 32'h400);
    host_send(0);
    wait_drain("t6", 500);
    check("t6_core3_cnt", wr_cnt[3], 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arbiter_pipein2fifo.md
Name: arbiter_pipein2fifo

Overview:
- Host-to-core distributor; the write-direction counterpart of the pipe-out arbiter.
- Host writes 32-bit words over the ok_clk pipe-in into an internal dual-clock FIFO.
- In the clk domain, a state machine walks the selected cores in ascending order and pushes exactly num_words words into each selected core's Neurram input FIFO.
- Sits between the Opal Kelly pipe-in endpoint and the 8 per-core I/O FIFOs.

Parameters:
- FIFO_SIZE, 256, depth of the internal 32-bit CDC FIFO. 4096 selects FIFO32x4096; any other value selects FIFO32x256.
- NUM_CORES, 8, number of core lanes. Fixed at 8; the port widths below assume it.

Ports:
- clk  input  1  core-side clock; FSM and internal FIFO read side
- rst  input  1  reset, asynchronous, active-high; also resets the internal FIFO
- ok_clk  input  1  host clock; internal FIFO write side
- pipe_in  input  32  host data word
- pipe_in_write  input  1  host write strobe, ok_clk domain
- pipe_in_full  output  1  internal FIFO full, ok_clk domain
- core_select  input  8  bit i set = core i receives a block
- num_words  input  8  words per selected core; 0 = skip all cores
- idle  output  1  high only in STATE_IDLE
- data_to_fifo  output  256  lane i = bits [32i+31:32i]
- wr_en_to_fifo  output  8  one-hot write enable to the core FIFOs
- full_from_fifo  input  8  per-core input FIFO full

Behaviour:
- Internal FIFO runs in first-word-fall-through mode. Its dout/empty are visible in clk; its rd_en is driven by the FSM.
- Host word order: num_words words for the lowest selected core, then the next selected core, and so on in ascending index order.
- Reset values: idle=1 (FSM enters STATE_IDLE). wr_en_to_fifo=0. data_to_fifo=0. Internal FIFO empty. pipe_in_full follows the FIFO reset behaviour.
- Registers: state (2b), addr_counter (4b), write_counter (8b). All async-reset to IDLE/0/0. All outputs are decoded combinationally from state and counters.
- STATE_IDLE (2'd1):
  - Outputs: idle=1, counters cleared.
  - Go to CHECK_ADDR when the internal FIFO is not empty and core_select != 0; otherwise stay.
- STATE_CHECK_ADDR (2'd2):
  - addr_counter >= 8: go to IDLE.
  - core_select[addr_counter]=1: go to TRANSFER with write_counter=0.
  - Otherwise: addr_counter+1, stay in CHECK_ADDR.
- STATE_TRANSFER (3'd3 encoded as 2'd3):
  - write_counter == num_words: addr_counter+1, go to CHECK_ADDR.
  - Otherwise:
    - data_to_fifo lane addr_counter = FIFO dout; all other lanes are 0.
    - Push condition: internal FIFO not empty and full_from_fifo[addr_counter]=0.
    - When the push condition holds: wr_en_to_fifo[addr_counter]=1, internal rd_en=1, write_counter+1, all in the same cycle.
    - When it does not hold: no write, no pop, counters hold. The FSM waits indefinitely; there is no timeout.
- Throughput: 1 word/clk when not stalled. Zero-cycle latency from pop to core write.
- Selection overhead: one CHECK_ADDR cycle per core index visited.
- Illegal state 2'd0: all outputs 0, go to IDLE.
- Boundary conditions:
  - core_select and num_words are sampled live, not latched. The host keeps them stable from the first pipe write until idle returns.
  - num_words=0 with a selected core: TRANSFER exits immediately; that core gets no writes.
  - num_words=255: 255 words; the counter never wraps.
  - Empty and core-full in the same cycle: stall; no pop.
  - Host writes while the internal FIFO is full: the word is dropped by the FIFO. The host must honour pipe_in_full.
  - rst mid-transfer: FSM goes to IDLE asynchronously, the internal FIFO is flushed, and the partial block is lost. Core FIFOs are not cleared here.

Decomposition:
- Shared package: NUM_CORES=8, WORD_W=32, and the state encodings STATE_IDLE/STATE_CHECK_ADDR/STATE_TRANSFER. These encodings are shared with the pipe-out arbiter.
- One sub-module: pipein_fifo_cdc. It holds the generate-select between FIFO32x256 and FIFO32x4096 (FWFT, async clocks) and exposes din/wr_en/full on ok_clk and dout/rd_en/empty on clk.

Test Plan:
- Reset, then core_select=8'h05, num_words=4, host writes 8 words 0x100..0x107 → core0 receives 0x100..0x103, then core2 receives 0x104..0x107. wr_en_to_fifo=8'h01 for 4 cycles, then 8'h04 for 4 cycles. idle=1 at end.
- core_select=8'h80, num_words=3, full_from_fifo[7] asserted for 5 clk after the first write → 3 writes total, none while full, counter holds, no word lost or duplicated.
- core_select=8'hFF, num_words=0, 1 word written → FSM passes through all 8 cores with zero writes, returns to IDLE, the word remains in the internal FIFO.
- core_select=8'h02, num_words=255, FIFO_SIZE=256, host streams 255 words while honouring pipe_in_full → exactly 255 writes to core1, data in order.
- Host trickles 1 word every 7 ok_clk, core_select=8'h10, num_words=6 → FSM stalls in TRANSFER on empty, 6 writes, wr_en never asserted while empty.
- rst pulsed after 2 of 4 words for core3 → idle=1 and wr_en_to_fifo=0 immediately. After release, a new 4-word block is delivered correctly to core3.
